ddr_ui_responder: RTL and testbench
===================================

Name: ddr_ui_responder

Overview:
- Synthesizable stand-in for the MIG 7-series user interface, i.e. the responder side of the app_* protocol driven by the DDR3 traffic generator.
- Accepts read and write commands and write-data beats, and stores 128-bit phrases in on-chip RAM.
- Returns read data in order after a fixed latency.
- Injects calibration delay and app_rdy/app_wdf_rdy backpressure, so initiators are exercised in simulation and on-board without DDR3.

Parameters:
ADDR_BITS, 10, log2 of stored phrase count (1024 phrases)
ADDR_SHIFT, 7, phrase index = app_addr >> ADDR_SHIFT, taken mod 2^ADDR_BITS
CMD_DEPTH, 8, command FIFO entries (power of 2)
WDF_DEPTH, 8, write-data FIFO entries (power of 2)
RD_LATENCY, 4, cycles from read retire to app_rd_data_valid (>=1)
CALIB_CYCLES, 64, cycles after reset release before init_calib_complete rises
STALL_PERIOD, 0, 0 = never stall; N>=2 = ready signals forced low one cycle in every N

Ports:
clk_in  input  1  ui clock
rst_n_in  input  1  asynchronous active-low reset
app_addr  input  27  command address
app_cmd  input  3  000 write, 001 read
app_en  input  1  command valid
app_wdf_data  input  128  write phrase
app_wdf_end  input  1  last beat of write burst (must accompany every wren)
app_wdf_wren  input  1  write data valid
app_wdf_mask  input  16  byte mask, 1 = byte not written
app_rd_data  output  128  read phrase
app_rd_data_end  output  1  equals app_rd_data_valid
app_rd_data_valid  output  1  read data strobe
app_rdy  output  1  command accepted when high with app_en
app_wdf_rdy  output  1  write data accepted when high with app_wdf_wren
app_sr_req  input  1  self-refresh request (ignored)
app_ref_req  input  1  refresh request
app_zq_req  input  1  ZQ request
app_sr_active  output  1  tied 0
app_ref_ack  output  1  one-cycle ack
app_zq_ack  output  1  one-cycle ack
init_calib_complete  output  1  calibration done
err_out  output  1  sticky protocol error

Behaviour:
Reset:
- Clock is clk_in; reset rst_n_in is asynchronous and active-low.
- While low: both FIFOs emptied, read pipeline valids cleared, calib counter, stall counter and err_out cleared.
- Outputs while in reset: app_rdy=0, app_wdf_rdy=0, app_rd_data_valid=0, app_rd_data=0, acks=0, init_calib_complete=0.
- RAM contents are not cleared.
- Reset asserted mid-operation discards queued commands, queued data and in-flight reads with no further valid pulses.

Calibration:
- Counter runs from reset release.
- init_calib_complete rises after exactly CALIB_CYCLES rising edges and then stays high.

Stall:
- stall = (STALL_PERIOD!=0) && (free-running counter mod STALL_PERIOD == STALL_PERIOD-1).

Ready signals:
- app_rdy = calib && !cmd_full && !stall.
- app_wdf_rdy = calib && !wdf_full && !stall.
- Both are combinational from registered state only, with no dependence on app_en or app_wdf_wren.

Command and data acceptance:
- A command is accepted on an edge with app_en && app_rdy; {cmd, index} is pushed to the command FIFO.
- A data beat is accepted on an edge with app_wdf_wren && app_wdf_rdy; {data, mask} is pushed to the write-data FIFO.
- Data may arrive before, with, or after its command.

Retire (at most one command per cycle, in order, at the command FIFO head):
- Write: retires only when the write-data FIFO is non-empty. Pops both FIFOs and writes unmasked bytes to RAM[index]. A head write with no data blocks all later commands.
- Read: retires unconditionally. Reads RAM[index] into the latency pipeline. app_rd_data_valid pulses for one cycle RD_LATENCY cycles after retire.
- Other cmd values: accepted, popped without effect, set err_out.

Ordering and latency:
- Read-after-write to the same index returns the new data, because retire is in order and the RAM write lands before any later read retires.
- Minimum read latency from the accept edge to the valid cycle is RD_LATENCY+1 cycles.
- Back-to-back reads give consecutive valid cycles.
- No backpressure on read data: the initiator must always accept it.

Full/empty:
- Push to the command FIFO happens same-cycle as a pop; full is computed on registered occupancy, so a full FIFO deasserts app_rdy even if the head retires that cycle.
- Push to an empty FIFO is visible for retire on the next cycle.

Index wrap:
- Addresses beyond 2^ADDR_BITS phrases alias modulo.

err_out:
- Sticky set also on an accepted beat with app_wdf_end=0, and on a push attempt when full (cannot occur with a compliant initiator).

Refresh/ZQ:
- app_ref_ack and app_zq_ack pulse high the cycle after the respective req is sampled high, once per rising edge of req.

Test Plan:
- Reset release with CALIB_CYCLES=64 -> init_calib_complete low for 64 edges, then high. app_rdy high the same cycle as calib (STALL_PERIOD=0).
- Write index 5 data 0x0123..CDEF mask 0, then read index 5 -> app_rd_data_valid exactly RD_LATENCY+1 cycles after the read accept, data 0x0123..CDEF, app_rd_data_end=1.
- Write to index 5 again with mask 0xFFFE over 0xFF..FF -> only byte 0 updated. Readback shows 0x0123..CDFF.
- Issue 8 write commands with no data -> app_rdy drops after the 8th accept. Push 8 beats -> all retire in order, app_rdy returns. Readback of all 8 matches.
- STALL_PERIOD=4, stream 1000 reads to a prefilled RAM -> app_rdy low every 4th cycle, 1000 valid pulses in address order, no error.
- Assert rst_n_in with 3 reads in flight -> valid drops immediately, no pulses after release. Cmd 3'b010 sets err_out, which holds until reset.

Source files
------------

// File: rtl/ddr_ui_responder_if.sv
// App-side bus of the DDR UI responder: command, write-data, read-data and
// maintenance request/ack signals. The initiator uses master, the responder slave.
interface ddr_ui_responder_if;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic [127:0] app_wdf_data;
  logic         app_wdf_end;
  logic         app_wdf_wren;
  logic [15:0]  app_wdf_mask;
  logic [127:0] app_rd_data;
  logic         app_rd_data_end;
  logic         app_rd_data_valid;
  logic         app_rdy;
  logic         app_wdf_rdy;
  logic         app_sr_req;
  logic         app_ref_req;
  logic         app_zq_req;
  logic         app_sr_active;
  logic         app_ref_ack;
  logic         app_zq_ack;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_wren, app_wdf_mask,
           app_sr_req, app_ref_req, app_zq_req,
    input  app_rd_data, app_rd_data_end, app_rd_data_valid, app_rdy, app_wdf_rdy,
           app_sr_active, app_ref_ack, app_zq_ack
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_wren, app_wdf_mask,
           app_sr_req, app_ref_req, app_zq_req,
    output app_rd_data, app_rd_data_end, app_rd_data_valid, app_rdy, app_wdf_rdy,
           app_sr_active, app_ref_ack, app_zq_ack
  );
endinterface

// File: rtl/ddr_ui_responder.sv
// Synthesizable stand-in for the MIG 7-series user interface. Commands and write
// beats queue in two FIFOs, retire in order into an on-chip phrase RAM, and reads
// return after a fixed pipeline latency. Calibration delay and periodic ready
// stalls exercise the initiator's flow control.
module ddr_ui_responder #(
  parameter int unsigned ADDR_BITS    = 10,
  parameter int unsigned ADDR_SHIFT   = 7,
  parameter int unsigned CMD_DEPTH    = 8,
  parameter int unsigned WDF_DEPTH    = 8,
  parameter int unsigned RD_LATENCY   = 4,
  parameter int unsigned CALIB_CYCLES = 64,
  parameter int unsigned STALL_PERIOD = 0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  ddr_ui_responder_if.slave app,
  output logic              init_calib_complete,
  output logic              err_out
);

  localparam int unsigned CmdPtrW = $clog2(CMD_DEPTH);
  localparam int unsigned CmdCntW = $clog2(CMD_DEPTH + 1);
  localparam int unsigned WdfPtrW = $clog2(WDF_DEPTH);
  localparam int unsigned WdfCntW = $clog2(WDF_DEPTH + 1);
  localparam int unsigned CalW    = $clog2(CALIB_CYCLES + 2);
  localparam int unsigned StallW  = $clog2(STALL_PERIOD + 2);

  typedef struct packed {
    logic [2:0]           cmd;
    logic [ADDR_BITS-1:0] idx;
  } cmd_entry_t;

  // Storage arrays carry no reset; only pointers and valids do.
  cmd_entry_t   cmd_mem      [CMD_DEPTH];
  logic [127:0] wdf_data_mem [WDF_DEPTH];
  logic [15:0]  wdf_mask_mem [WDF_DEPTH];
  logic [127:0] ram_mem      [2**ADDR_BITS];

  logic [CmdPtrW-1:0]    cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
  logic [CmdCntW-1:0]    cmd_cnt_q, cmd_cnt_d;
  logic [WdfPtrW-1:0]    wdf_wptr_q, wdf_wptr_d, wdf_rptr_q, wdf_rptr_d;
  logic [WdfCntW-1:0]    wdf_cnt_q, wdf_cnt_d;
  logic [CalW-1:0]       calib_cnt_q, calib_cnt_d;
  logic [StallW-1:0]     stall_cnt_q, stall_cnt_d;
  logic                  err_q, err_d;
  logic [RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [127:0]          rd_data_q [RD_LATENCY];
  logic [127:0]          rd_data_d [RD_LATENCY];
  logic                  ref_req_q, ref_ack_q, ref_ack_d;
  logic                  zq_req_q, zq_ack_q, zq_ack_d;

  logic                 calib, stall;
  logic                 cmd_full, cmd_empty, wdf_full, wdf_empty;
  logic                 cmd_push, wdf_push;
  logic                 retire, wr_retire, rd_retire, bad_retire;
  logic                 rdy, wdf_rdy;
  cmd_entry_t           head;
  logic [ADDR_BITS-1:0] push_idx;
  logic                 unused_sr;

  // Handshake and retire decode; ready depends only on registered state.
  always_comb begin
    calib     = (calib_cnt_q == CalW'(CALIB_CYCLES));
    stall     = (STALL_PERIOD != 0) && (stall_cnt_q == StallW'(STALL_PERIOD - 1));
    cmd_full  = (cmd_cnt_q == CmdCntW'(CMD_DEPTH));
    cmd_empty = (cmd_cnt_q == '0);
    wdf_full  = (wdf_cnt_q == WdfCntW'(WDF_DEPTH));
    wdf_empty = (wdf_cnt_q == '0);
    rdy       = calib && !cmd_full && !stall;
    wdf_rdy   = calib && !wdf_full && !stall;
    cmd_push  = app.app_en && rdy;
    wdf_push  = app.app_wdf_wren && wdf_rdy;
    push_idx  = ADDR_BITS'(app.app_addr >> ADDR_SHIFT);
    head      = cmd_mem[cmd_rptr_q];
    // A head write waits for its data beat and blocks everything behind it.
    retire     = !cmd_empty && ((head.cmd != 3'b000) || !wdf_empty);
    wr_retire  = retire && (head.cmd == 3'b000);
    rd_retire  = retire && (head.cmd == 3'b001);
    bad_retire = retire && (head.cmd != 3'b000) && (head.cmd != 3'b001);
  end

  // Next-state for counters, FIFO pointers, read pipeline, error and acks.
  always_comb begin
    calib_cnt_d = calib ? calib_cnt_q : calib_cnt_q + CalW'(1);
    stall_cnt_d = ((STALL_PERIOD == 0) || stall) ? '0 : stall_cnt_q + StallW'(1);

    cmd_wptr_d = cmd_push ? cmd_wptr_q + CmdPtrW'(1) : cmd_wptr_q;
    cmd_rptr_d = retire ? cmd_rptr_q + CmdPtrW'(1) : cmd_rptr_q;
    cmd_cnt_d  = cmd_cnt_q;
    if (cmd_push && !retire)      cmd_cnt_d = cmd_cnt_q + CmdCntW'(1);
    else if (!cmd_push && retire) cmd_cnt_d = cmd_cnt_q - CmdCntW'(1);

    wdf_wptr_d = wdf_push ? wdf_wptr_q + WdfPtrW'(1) : wdf_wptr_q;
    wdf_rptr_d = wr_retire ? wdf_rptr_q + WdfPtrW'(1) : wdf_rptr_q;
    wdf_cnt_d  = wdf_cnt_q;
    if (wdf_push && !wr_retire)      wdf_cnt_d = wdf_cnt_q + WdfCntW'(1);
    else if (!wdf_push && wr_retire) wdf_cnt_d = wdf_cnt_q - WdfCntW'(1);

    rd_vld_d[0]  = rd_retire;
    rd_data_d[0] = ram_mem[head.idx];
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_vld_d[i]  = rd_vld_q[i-1];
      rd_data_d[i] = rd_data_q[i-1];
    end

    err_d = err_q | bad_retire | (wdf_push && !app.app_wdf_end) |
            (cmd_push && cmd_full) | (wdf_push && wdf_full);

    ref_ack_d = app.app_ref_req && !ref_req_q;
    zq_ack_d  = app.app_zq_req && !zq_req_q;
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cmd_wptr_q  <= '0;
      cmd_rptr_q  <= '0;
      cmd_cnt_q   <= '0;
      wdf_wptr_q  <= '0;
      wdf_rptr_q  <= '0;
      wdf_cnt_q   <= '0;
      calib_cnt_q <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
      rd_vld_q    <= '0;
      ref_req_q   <= 1'b0;
      ref_ack_q   <= 1'b0;
      zq_req_q    <= 1'b0;
      zq_ack_q    <= 1'b0;
    end else begin
      cmd_wptr_q  <= cmd_wptr_d;
      cmd_rptr_q  <= cmd_rptr_d;
      cmd_cnt_q   <= cmd_cnt_d;
      wdf_wptr_q  <= wdf_wptr_d;
      wdf_rptr_q  <= wdf_rptr_d;
      wdf_cnt_q   <= wdf_cnt_d;
      calib_cnt_q <= calib_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
      rd_vld_q    <= rd_vld_d;
      ref_req_q   <= app.app_ref_req;
      ref_ack_q   <= ref_ack_d;
      zq_req_q    <= app.app_zq_req;
      zq_ack_q    <= zq_ack_d;
    end
  end

  // FIFO storage, byte-masked RAM write and read-data pipeline.
  always_ff @(posedge clk_in) begin
    if (cmd_push) cmd_mem[cmd_wptr_q] <= '{cmd: app.app_cmd, idx: push_idx};
    if (wdf_push) begin
      wdf_data_mem[wdf_wptr_q] <= app.app_wdf_data;
      wdf_mask_mem[wdf_wptr_q] <= app.app_wdf_mask;
    end
    for (int b = 0; b < 16; b++) begin
      if (wr_retire && !wdf_mask_mem[wdf_rptr_q][b]) begin
        ram_mem[head.idx][8*b +: 8] <= wdf_data_mem[wdf_rptr_q][8*b +: 8];
      end
    end
    for (int i = 0; i < RD_LATENCY; i++) rd_data_q[i] <= rd_data_d[i];
  end

  assign app.app_rdy           = rdy;
  assign app.app_wdf_rdy       = wdf_rdy;
  assign app.app_rd_data_valid = rd_vld_q[RD_LATENCY-1];
  assign app.app_rd_data_end   = rd_vld_q[RD_LATENCY-1];
  // Gate data with valid so the bus reads zero in reset without clearing the pipe.
  assign app.app_rd_data       = rd_vld_q[RD_LATENCY-1] ? rd_data_q[RD_LATENCY-1] : '0;
  assign app.app_sr_active     = 1'b0;
  assign app.app_ref_ack       = ref_ack_q;
  assign app.app_zq_ack        = zq_ack_q;
  assign init_calib_complete   = calib;
  assign err_out               = err_q;
  assign unused_sr             = app.app_sr_req;

endmodule

// File: tb/tb_ddr_ui_responder.sv
// Directed bench for ddr_ui_responder: dut_a uses default parameters, dut_b adds
// a ready stall every 4th cycle.
module tb_ddr_ui_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr_ui_responder_if ifa ();
  ddr_ui_responder_if ifb ();
  logic calib_a, calib_b, err_a, err_b;

  ddr_ui_responder dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .app(ifa.slave),
    .init_calib_complete(calib_a), .err_out(err_a)
  );

  ddr_ui_responder #(.STALL_PERIOD(4)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .app(ifb.slave),
    .init_calib_complete(calib_b), .err_out(err_b)
  );

  // Shared stimulus, steered to one DUT by sel.
  logic         sel = 1'b0;
  logic [26:0]  addr = '0;
  logic [2:0]   cmd = '0;
  logic         en = 1'b0, wren = 1'b0, wend = 1'b1;
  logic [127:0] wdata = '0;
  logic [15:0]  wmask = '0;
  logic         ref_req = 1'b0, zq_req = 1'b0;
  logic         rdy_sel, wrdy_sel;

  assign ifa.app_addr = addr;       assign ifb.app_addr = addr;
  assign ifa.app_cmd = cmd;         assign ifb.app_cmd = cmd;
  assign ifa.app_en = en & ~sel;    assign ifb.app_en = en & sel;
  assign ifa.app_wdf_data = wdata;  assign ifb.app_wdf_data = wdata;
  assign ifa.app_wdf_end = wend;    assign ifb.app_wdf_end = wend;
  assign ifa.app_wdf_wren = wren & ~sel;
  assign ifb.app_wdf_wren = wren & sel;
  assign ifa.app_wdf_mask = wmask;  assign ifb.app_wdf_mask = wmask;
  assign ifa.app_sr_req = 1'b0;     assign ifb.app_sr_req = 1'b0;
  assign ifa.app_ref_req = ref_req; assign ifb.app_ref_req = 1'b0;
  assign ifa.app_zq_req = zq_req;   assign ifb.app_zq_req = 1'b0;
  assign rdy_sel  = sel ? ifb.app_rdy : ifa.app_rdy;
  assign wrdy_sel = sel ? ifb.app_wdf_rdy : ifa.app_wdf_rdy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int scnt    = 0;

  always @(posedge clk) cyc <= cyc + 1;
  // Edges since reset release, the reference for the stall cadence.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) scnt <= 0;
    else        scnt <= scnt + 1;
  end

  function automatic logic [127:0] pat_b(input int i);
    return {i[31:0], ~i[31:0], 32'h5A5A_0000 ^ i[31:0], 32'(i * 3)};
  endfunction

  function automatic logic [127:0] pat8(input int i);
    return {4{32'hC0DE_0000 | i[31:0]}};
  endfunction

  // Read-data monitors.
  logic [127:0] rq_a [$];
  int           rt_a [$];
  int end_bad = 0, b_cnt = 0, b_bad = 0, stall_bad = 0, stall_seen = 0;
  bit stall_chk = 1'b0;

  always @(negedge clk) begin
    if (ifa.app_rd_data_valid) begin
      rq_a.push_back(ifa.app_rd_data);
      rt_a.push_back(cyc);
    end
    if ((ifa.app_rd_data_end !== ifa.app_rd_data_valid) ||
        (ifb.app_rd_data_end !== ifb.app_rd_data_valid)) end_bad <= end_bad + 1;
    if (ifb.app_rd_data_valid) begin
      if (ifb.app_rd_data !== pat_b(b_cnt)) b_bad <= b_bad + 1;
      b_cnt <= b_cnt + 1;
    end
    if (stall_chk) begin
      if (ifb.app_rdy !== ((scnt % 4) != 3)) stall_bad <= stall_bad + 1;
      if (!ifb.app_rdy) stall_seen <= stall_seen + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send_cmd(input logic [2:0] c, input logic [26:0] a, output int acc);
    int k = 0;
    cmd = c; addr = a; en = 1'b1;
    while (!rdy_sel && k < 5000) begin @(negedge clk); k++; end
    if (!rdy_sel) check_eq("cmd_timeout", 128'(rdy_sel), 128'd1);
    acc = cyc;
    @(posedge clk); #1 en = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [15:0] m, input logic e);
    int k = 0;
    wdata = d; wmask = m; wend = e; wren = 1'b1;
    while (!wrdy_sel && k < 5000) begin @(negedge clk); k++; end
    if (!wrdy_sel) check_eq("beat_timeout", 128'(wrdy_sel), 128'd1);
    @(posedge clk); #1 wren = 1'b0; wend = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_write(input int idx, input logic [127:0] d, input logic [15:0] m);
    int acc;
    send_cmd(3'b000, 27'(idx << 7), acc);
    send_beat(d, m, 1'b1);
  endtask

  task automatic read_check_a(input int idx, input logic [127:0] exp, input string tag);
    int n, acc;
    int k = 0;
    n = rq_a.size();
    send_cmd(3'b001, 27'(idx << 7), acc);
    while (rq_a.size() <= n && k < 100) begin @(negedge clk); k++; end
    if (rq_a.size() <= n) begin
      check_eq({tag, "_timeout"}, 128'(rq_a.size()), 128'(n + 1));
    end else begin
      check_eq(tag, rq_a[n], exp);
      check_eq({tag, "_lat"}, 128'(rt_a[n] - acc), 128'd5);
    end
  endtask

  task automatic wait_calib();
    int k = 0;
    while (!calib_a && k < 200) begin @(negedge clk); k++; end
    check_eq("recalib", 128'(calib_a), 128'd1);
  endtask

  localparam logic [127:0] D0 = 128'h0123456789ABCDEF_0123456789ABCDEF;
  localparam logic [127:0] D1 = 128'h0123456789ABCDEF_0123456789ABCDFF;
  localparam logic [127:0] W7 = 128'hDEADBEEF_00000007_CAFEF00D_12345678;

  initial begin
    int acc, n, k;
    repeat (3) @(negedge clk);
    check_eq("rst_rdy", 128'({ifa.app_rdy, ifa.app_wdf_rdy}), 128'd0);
    check_eq("rst_rd", 128'({ifa.app_rd_data_valid, ifa.app_ref_ack, ifa.app_zq_ack}), 128'd0);
    check_eq("rst_rdata", ifa.app_rd_data, 128'd0);
    check_eq("rst_calib_err", 128'({calib_a, err_a}), 128'd0);

    // Calibration: low for 63 edges after release, high on the 64th.
    rst_n = 1'b1;
    repeat (63) @(posedge clk);
    #1 check_eq("calib_63", 128'({calib_a, ifa.app_rdy}), 128'd0);
    @(posedge clk);
    #1 check_eq("calib_64", 128'({calib_a, ifa.app_rdy, ifa.app_wdf_rdy}), 128'b111);
    @(negedge clk);

    // Full write, readback with latency, then masked byte update.
    do_write(5, D0, 16'h0000);
    read_check_a(5, D0, "rd_idx5");
    do_write(5, {128{1'b1}}, 16'hFFFE);
    read_check_a(5, D1, "rd_mask");
    // Index 1031 aliases to 7.
    do_write(1024 + 7, W7, 16'h0000);
    read_check_a(7, W7, "rd_alias");
    check_eq("sr_active", 128'(ifa.app_sr_active), 128'd0);

    // Refresh and ZQ acks: one pulse per request rising edge.
    ref_req = 1'b1;
    @(posedge clk); #1 check_eq("ref_ack_1", 128'(ifa.app_ref_ack), 128'd1);
    @(posedge clk); #1 check_eq("ref_ack_0", 128'(ifa.app_ref_ack), 128'd0);
    @(negedge clk); ref_req = 1'b0; zq_req = 1'b1;
    @(posedge clk); #1 check_eq("zq_ack_1", 128'(ifa.app_zq_ack), 128'd1);
    @(posedge clk); #1 check_eq("zq_ack_0", 128'(ifa.app_zq_ack), 128'd0);
    @(negedge clk); zq_req = 1'b0;

    // Eight writes with no data fill the command FIFO.
    for (int i = 0; i < 8; i++) send_cmd(3'b000, 27'((16 + i) << 7), acc);
    check_eq("cmd_full_rdy", 128'({ifa.app_rdy, ifa.app_wdf_rdy}), 128'b01);
    for (int i = 0; i < 8; i++) send_beat(pat8(i), 16'h0000, 1'b1);
    repeat (2) @(negedge clk);
    check_eq("cmd_drain_rdy", 128'(ifa.app_rdy), 128'd1);
    for (int i = 0; i < 8; i++) read_check_a(16 + i, pat8(i), $sformatf("rd_fill%0d", i));

    // Stalling DUT: prefill, then stream 1000 reads.
    sel = 1'b1;
    for (int i = 0; i < 1000; i++) do_write(i, pat_b(i), 16'h0000);
    repeat (4) @(negedge clk);
    stall_chk = 1'b1;
    for (int i = 0; i < 1000; i++) send_cmd(3'b001, 27'(i << 7), acc);
    stall_chk = 1'b0;
    k = 0;
    while (b_cnt < 1000 && k < 200) begin @(negedge clk); k++; end
    check_eq("b_count", 128'(b_cnt), 128'd1000);
    check_eq("b_data", 128'(b_bad), 128'd0);
    check_eq("b_stall_cadence", 128'(stall_bad), 128'd0);
    check_eq("b_stall_seen", 128'(stall_seen >= 200), 128'd1);
    check_eq("b_err", 128'(err_b), 128'd0);
    sel = 1'b0;

    // Reset with three reads in flight.
    n = rq_a.size();
    for (int i = 0; i < 3; i++) send_cmd(3'b001, 27'((16 + i) << 7), acc);
    rst_n = 1'b0;
    #1 check_eq("mid_rst_vld", 128'(ifa.app_rd_data_valid), 128'd0);
    check_eq("mid_rst_data", ifa.app_rd_data, 128'd0);
    check_eq("mid_rst_rdy", 128'({ifa.app_rdy, calib_a}), 128'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("no_pulse_after_rst", 128'(rq_a.size()), 128'(n));
    wait_calib();
    read_check_a(5, D1, "ram_kept");

    // Illegal command sets a sticky error cleared only by reset.
    check_eq("err_pre", 128'(err_a), 128'd0);
    send_cmd(3'b010, 27'd0, acc);
    repeat (3) @(negedge clk);
    check_eq("err_badcmd", 128'(err_a), 128'd1);
    repeat (10) @(negedge clk);
    check_eq("err_sticky", 128'(err_a), 128'd1);
    rst_n = 1'b0;
    #1 check_eq("err_rst", 128'(err_a), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_calib();

    // A beat without app_wdf_end is also an error.
    send_beat(D0, 16'h0000, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("err_noend", 128'(err_a), 128'd1);
    check_eq("rd_end_eq_valid", 128'(end_bad), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
